// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating dot-product accumulation stage of the NPU MAC unit.
//
// Takes signed partial products from the multiplier tree one beat at a time.
// Each beat is sign-extended and added into an ACC_W-bit accumulator that
// clamps at both ends. A beat with Prod_Last closes the vector. The result is
// then presented under a valid/ready handshake and held until the consumer
// takes it.
//
// Ports:
//   Clk         clock; all state updates on the rising edge
//   Rst         synchronous, active-high reset
//   Prod_In     PROD_W-bit two's-complement product
//   Prod_Valid  Prod_In / Prod_Last qualify this cycle
//   Prod_Last   this beat closes the current vector
//   Prod_Ready  a beat can be accepted this cycle (registered)
//   Acc_Out     ACC_W-bit signed result, valid only while Acc_Valid (registered)
//   Acc_Valid   result available (registered)
//   Acc_Ready   consumer takes the result this cycle
//   Sat_Flag    sticky: the presented vector saturated at least once (registered)
//   Count_Out   number of beats summed into the presented result (registered)
module mac_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [PROD_W-1:0] Prod_In,
  input  logic              Prod_Valid,
  input  logic              Prod_Last,
  output logic              Prod_Ready,
  output logic [ACC_W-1:0]  Acc_Out,
  output logic              Acc_Valid,
  input  logic              Acc_Ready,
  output logic              Sat_Flag,
  output logic [CNT_W-1:0]  Count_Out
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned EXT_W = ACC_W - PROD_W;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  logic             accept;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_base;
  logic [SUM_W-1:0] sum_wide;
  logic             ovf_pos;
  logic             ovf_neg;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;

  // Prod_Ready is a register that is only ever high outside HOLD.
  assign accept = Prod_Valid & Prod_Ready;

  // Sign-extend the incoming product to accumulator width.
  assign prod_ext = {{EXT_W{Prod_In[PROD_W-1]}}, Prod_In};

  // The first beat of a vector starts from zero regardless of what acc holds.
  assign acc_base = (state == IDLE) ? '0 : acc;

  // One guard bit is enough to detect overflow of a two-operand signed add.
  assign sum_wide = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
  assign ovf_pos  = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
  assign ovf_neg  =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];

  // Next accumulator, sticky-saturation and beat-count values for an accepted beat.
  always_comb begin
    acc_next = sum_wide[ACC_W-1:0];
    cnt_next = cnt;
    sat_next = sat;

    if (ovf_pos) begin
      acc_next = ACC_MAX;
    end else if (ovf_neg) begin
      acc_next = ACC_MIN;
    end

    if (state == IDLE) begin
      cnt_next = CNT_W'(1);
      sat_next = 1'b0;
    end else begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      sat_next = sat | ovf_pos | ovf_neg;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      sat        <= 1'b0;
      Prod_Ready <= 1'b1;
      Acc_Out    <= '0;
      Acc_Valid  <= 1'b0;
      Sat_Flag   <= 1'b0;
      Count_Out  <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            sat <= sat_next;
            if (Prod_Last) begin
              // Result registers load from the same next values the
              // internal state takes, so they appear one edge after the last beat.
              state      <= HOLD;
              Prod_Ready <= 1'b0;
              Acc_Valid  <= 1'b1;
              Acc_Out    <= acc_next;
              Sat_Flag   <= sat_next;
              Count_Out  <= cnt_next;
            end else begin
              state <= ACCUM;
            end
          end
        end

        HOLD: begin
          if (Acc_Ready) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            Prod_Ready <= 1'b1;
            Acc_Out    <= '0;
            Acc_Valid  <= 1'b0;
            Sat_Flag   <= 1'b0;
            Count_Out  <= '0;
          end
        end

        default: begin
          state      <= IDLE;
          acc        <= '0;
          cnt        <= '0;
          sat        <= 1'b0;
          Prod_Ready <= 1'b1;
          Acc_Out    <= '0;
          Acc_Valid  <= 1'b0;
          Sat_Flag   <= 1'b0;
          Count_Out  <= '0;
        end
      endcase
    end
  end

endmodule
